// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM state encoding,
// instruction width and the NOP word used for reset and faults.
package fetch_pkg;

    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h00000013;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_WAIT    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_FAULT   = 3'd4
    } fetch_state_t;

endpackage

// File: rtl/pc_unit.sv
// Architectural PC register with branch-condition evaluation and next-PC
// selection. Updates on every cycle a write strobe qualifies, regardless of
// what the fetch FSM is doing.
module pc_unit #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pc_write,
    input  logic            pc_write_cond,
    input  logic            branch_op,
    input  logic            pc_src,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] alu_out,
    input  logic            alu_zero,
    output logic [XLEN-1:0] pc
);

    logic            branch_taken;
    logic            pc_en;
    logic [XLEN-1:0] pc_next;

    // BEQ takes on zero, BNE on non-zero; XOR with branch_op folds both.
    always_comb begin
        branch_taken = pc_write_cond & (alu_zero ^ branch_op);
        pc_en        = pc_write | branch_taken;
        pc_next      = pc_src ? alu_out : alu_result;
    end

    // PC register; wraps naturally at XLEN bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (pc_en) begin
            pc <= pc_next;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: request/acknowledge handshake with instruction
// memory, instruction register and PC ownership.
// Optional feature macro: INSTR_FETCH_WATCHDOG_EN -- when defined, a 4-bit
// counter aborts a fetch that has not been acknowledged within TIMEOUT cycles.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              TIMEOUT  = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               fetch_req,
    input  logic               pc_write,
    input  logic               pc_write_cond,
    input  logic               branch_op,
    input  logic               pc_src,
    input  logic [XLEN-1:0]    alu_result,
    input  logic [XLEN-1:0]    alu_out,
    input  logic               alu_zero,
    output logic [XLEN-1:0]    imem_addr,
    output logic               imem_req,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_err,
    output logic [INSTR_W-1:0] instruction,
    output logic [XLEN-1:0]    instr_pc,
    output logic               instr_valid,
    output logic [XLEN-1:0]    pc,
    output logic               fetch_busy,
    output logic               fetch_fault
);

    fetch_state_t       state;
    logic [INSTR_W-1:0] rsp_data;
    logic               rsp_err;

`ifdef INSTR_FETCH_WATCHDOG_EN
    logic [3:0] wdog_cnt;
    localparam logic [3:0] WDOG_LAST = 4'(TIMEOUT - 1);
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
`endif

    pc_unit #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc_unit (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .branch_op     (branch_op),
        .pc_src        (pc_src),
        .alu_result    (alu_result),
        .alu_out       (alu_out),
        .alu_zero      (alu_zero),
        .pc            (pc)
    );

    // Fetch FSM with registered outputs; imem_req clears asynchronously on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            imem_addr   <= RESET_PC;
            imem_req    <= 1'b0;
            fetch_busy  <= 1'b0;
            instruction <= NOP_INSTR;
            instr_pc    <= RESET_PC;
            instr_valid <= 1'b0;
            fetch_fault <= 1'b0;
            rsp_data    <= NOP_INSTR;
            rsp_err     <= 1'b0;
`ifdef INSTR_FETCH_WATCHDOG_EN
            wdog_cnt    <= 4'd0;
`endif
        end else begin
            instr_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (fetch_req) begin
                        if (pc[1:0] != 2'b00) begin
                            state <= ST_FAULT;
                        end else begin
                            // Address is frozen here until the response is captured.
                            imem_addr  <= pc;
                            imem_req   <= 1'b1;
                            fetch_busy <= 1'b1;
                            state      <= ST_REQ;
`ifdef INSTR_FETCH_WATCHDOG_EN
                            wdog_cnt   <= 4'd0;
`endif
                        end
                    end
                end
                ST_REQ, ST_WAIT: begin
                    if (imem_ack) begin
                        rsp_data   <= imem_rdata;
                        rsp_err    <= imem_err;
                        imem_req   <= 1'b0;
                        fetch_busy <= 1'b0;
                        state      <= ST_CAPTURE;
                    end
`ifdef INSTR_FETCH_WATCHDOG_EN
                    else if (wdog_cnt == WDOG_LAST) begin
                        imem_req   <= 1'b0;
                        fetch_busy <= 1'b0;
                        state      <= ST_FAULT;
                    end else begin
                        wdog_cnt <= wdog_cnt + 4'd1;
                        state    <= ST_WAIT;
                    end
`else
                    else begin
                        state <= ST_WAIT;
                    end
`endif
                end
                ST_CAPTURE: begin
                    if (rsp_err) begin
                        state <= ST_FAULT;
                    end else begin
                        instruction <= rsp_data;
                        instr_pc    <= imem_addr;
                        instr_valid <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                ST_FAULT: begin
                    // Hand the control unit a NOP so it never decodes garbage.
                    instruction <= NOP_INSTR;
                    fetch_fault <= 1'b1;
                    instr_valid <= 1'b1;
                    state       <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch. Inputs change 1 ns after the
// rising edge and outputs are sampled at that same point, away from the edge.
module tb_instr_fetch;

    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            fetch_req;
    logic            pc_write;
    logic            pc_write_cond;
    logic            branch_op;
    logic            pc_src;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] alu_out;
    logic            alu_zero;
    logic [XLEN-1:0] imem_addr;
    logic            imem_req;
    logic            imem_ack;
    logic [31:0]     imem_rdata;
    logic            imem_err;
    logic [31:0]     instruction;
    logic [XLEN-1:0] instr_pc;
    logic            instr_valid;
    logic [XLEN-1:0] pc;
    logic            fetch_busy;
    logic            fetch_fault;

    int checks = 0;
    int errors = 0;
    int n_req;

    instr_fetch #(
        .XLEN     (XLEN),
        .RESET_PC (64'h0),
        .TIMEOUT  (15)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fetch_req     (fetch_req),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .branch_op     (branch_op),
        .pc_src        (pc_src),
        .alu_result    (alu_result),
        .alu_out       (alu_out),
        .alu_zero      (alu_zero),
        .imem_addr     (imem_addr),
        .imem_req      (imem_req),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .imem_err      (imem_err),
        .instruction   (instruction),
        .instr_pc      (instr_pc),
        .instr_valid   (instr_valid),
        .pc            (pc),
        .fetch_busy    (fetch_busy),
        .fetch_fault   (fetch_fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; fetch_req = 1'b0; pc_write = 1'b0; pc_write_cond = 1'b0;
        branch_op = 1'b0; pc_src = 1'b0; alu_result = '0; alu_out = '0;
        alu_zero = 1'b0; imem_ack = 1'b0; imem_rdata = '0; imem_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        check("rst_pc", pc, 64'h0);
        check("rst_instr", instruction, 64'h13);
        check("rst_instr_pc", instr_pc, 64'h0);
        check("rst_addr", imem_addr, 64'h0);
        check("rst_req", imem_req, 1'b0);
        check("rst_valid", instr_valid, 1'b0);
        check("rst_busy", fetch_busy, 1'b0);
        check("rst_fault", fetch_fault, 1'b0);
        rst_n = 1'b1;
        tick();

        // Zero-wait fetch: valid in t+3
        fetch_req = 1'b1; tick(); fetch_req = 1'b0;
        check("zw_req", imem_req, 1'b1);
        check("zw_busy", fetch_busy, 1'b1);
        check("zw_addr", imem_addr, 64'h0);
        imem_ack = 1'b1; imem_rdata = 32'h00A00093; tick();
        imem_ack = 1'b0; imem_rdata = '0;
        check("zw_t2_valid", instr_valid, 1'b0);
        check("zw_t2_req", imem_req, 1'b0);
        tick();
        check("zw_t3_valid", instr_valid, 1'b1);
        check("zw_t3_instr", instruction, 64'h00A00093);
        check("zw_t3_instr_pc", instr_pc, 64'h0);
        tick();
        check("zw_t4_valid", instr_valid, 1'b0);
        check("zw_t4_hold", instruction, 64'h00A00093);

        // Unconditional write, pc_src = 0
        pc_write = 1'b1; alu_result = 64'h10; tick(); pc_write = 1'b0;
        check("pcw_pc", pc, 64'h10);

        // Three wait states, PC write during WAIT, stray fetch_req ignored
        fetch_req = 1'b1; tick(); fetch_req = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            check("ws_req", imem_req, 1'b1);
            check("ws_addr", imem_addr, 64'h10);
            if (i == 2) begin pc_write = 1'b1; alu_result = 64'h8; end
            if (i == 3) begin check("ws_pc_upd", pc, 64'h8); fetch_req = 1'b1; end
            if (i == 4) begin imem_ack = 1'b1; imem_rdata = 32'h00108113; end
            tick();
            pc_write = 1'b0; fetch_req = 1'b0; imem_ack = 1'b0;
        end
        check("ws_t5_valid", instr_valid, 1'b0);
        check("ws_t5_req", imem_req, 1'b0);
        tick();
        check("ws_t6_valid", instr_valid, 1'b1);
        check("ws_t6_instr", instruction, 64'h00108113);
        check("ws_t6_instr_pc", instr_pc, 64'h10);
        check("ws_t6_pc", pc, 64'h8);
        tick();
        check("ws_ignored_req", imem_req, 1'b0);
        check("ws_ignored_busy", fetch_busy, 1'b0);

        // Conditional branches
        pc_write_cond = 1'b1; branch_op = 1'b0; alu_zero = 1'b1; pc_src = 1'b1;
        alu_out = 64'h40; tick();
        check("beq_taken", pc, 64'h40);
        branch_op = 1'b1; alu_out = 64'h80; tick();
        check("bne_not_taken", pc, 64'h40);
        alu_zero = 1'b0; alu_out = 64'h44; tick();
        check("bne_taken", pc, 64'h44);
        branch_op = 1'b0; alu_out = 64'h90; tick();
        check("beq_not_taken", pc, 64'h44);
        pc_write_cond = 1'b0; pc_src = 1'b0;

        // Fetch and PC update in the same IDLE cycle, then bus error
        fetch_req = 1'b1; pc_write = 1'b1; alu_result = 64'h100; tick();
        fetch_req = 1'b0; pc_write = 1'b0;
        check("same_addr", imem_addr, 64'h44);
        check("same_pc", pc, 64'h100);
        imem_ack = 1'b1; imem_err = 1'b1; imem_rdata = 32'hDEADBEEF; tick();
        imem_ack = 1'b0; imem_err = 1'b0;
        tick();
        check("err_pre_valid", instr_valid, 1'b0);
        check("err_pre_fault", fetch_fault, 1'b0);
        tick();
        check("err_valid", instr_valid, 1'b1);
        check("err_fault", fetch_fault, 1'b1);
        check("err_instr", instruction, 64'h13);

        // Reset clears the sticky fault
        rst_n = 1'b0; #1;
        check("rst2_fault", fetch_fault, 1'b0);
        check("rst2_pc", pc, 64'h0);
        rst_n = 1'b1; tick();

        // Wrap-free extreme value and misaligned fetch
        pc_write = 1'b1; alu_result = 64'hFFFF_FFFF_FFFF_FFFC; tick();
        check("pc_max", pc, 64'hFFFF_FFFF_FFFF_FFFC);
        alu_result = 64'h2; tick(); pc_write = 1'b0;
        check("pc_misal", pc, 64'h2);
        fetch_req = 1'b1; tick(); fetch_req = 1'b0;
        check("mis_req", imem_req, 1'b0);
        tick();
        check("mis_fault", fetch_fault, 1'b1);
        check("mis_valid", instr_valid, 1'b1);
        check("mis_instr", instruction, 64'h13);
        check("mis_req2", imem_req, 1'b0);

        // Reset mid-WAIT drops imem_req at once; late ack ignored
        rst_n = 1'b0; #1; rst_n = 1'b1; tick();
        fetch_req = 1'b1; tick(); fetch_req = 1'b0;
        tick();
        check("mid_req_before", imem_req, 1'b1);
        #2; rst_n = 1'b0; #1;
        check("mid_req_async", imem_req, 1'b0);
        check("mid_busy_async", fetch_busy, 1'b0);
        #2; rst_n = 1'b1;
        imem_ack = 1'b1; imem_rdata = 32'h12345678; tick(); imem_ack = 1'b0;
        tick();
        check("late_ack_valid", instr_valid, 1'b0);
        tick();
        check("late_ack_valid2", instr_valid, 1'b0);
        check("late_ack_instr", instruction, 64'h13);
        check("late_ack_req", imem_req, 1'b0);

        // Long wait: aborted by the watchdog or held indefinitely
        fetch_req = 1'b1; tick(); fetch_req = 1'b0;
        n_req = 0;
`ifdef INSTR_FETCH_WATCHDOG_EN
        for (int i = 0; i < 40; i++) begin
            if (imem_req) n_req++;
            else break;
            tick();
        end
        check("wdog_req_cycles", n_req, 15);
        tick();
        check("wdog_fault", fetch_fault, 1'b1);
        check("wdog_valid", instr_valid, 1'b1);
`else
        for (int i = 0; i < 20; i++) begin
            if (imem_req) n_req++;
            tick();
        end
        check("nowd_req_cycles", n_req, 20);
        check("nowd_addr", imem_addr, 64'h0);
        imem_ack = 1'b1; imem_rdata = 32'h00000073; tick(); imem_ack = 1'b0;
        tick();
        check("nowd_valid", instr_valid, 1'b1);
        check("nowd_instr", instruction, 64'h73);
        check("nowd_fault", fetch_fault, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
